// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared widths and next-PC select encoding for the PC generator
package pc_gen_pkg;

  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // The two low PC bits never reach the BTB: fetch addresses are word aligned.
  function automatic int btb_tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_PRED,
    SEL_SEQ
  } next_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - IF-stage control/EX-resolution inputs and fetch-PC outputs of pc_gen
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            trap;
  logic            ex_valid;
  logic            ex_mispredict;
  logic            ex_jalr;
  logic            ex_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs_imm;
  logic [XLEN-1:0] pc_addr;
  logic [XLEN-1:0] pc_save;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall, trap, ex_valid, ex_mispredict, ex_jalr, ex_taken,
           ex_pc, ex_imm, ex_rs_imm,
    input  pc_addr, pc_save, pred_taken, pred_target
  );

  modport slave (
    input  stall, trap, ex_valid, ex_mispredict, ex_jalr, ex_taken,
           ex_pc, ex_imm, ex_rs_imm,
    output pc_addr, pc_save, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_btb.sv
// rtl/pc_btb.sv - direct-mapped branch target buffer with async valid clear
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-3:0] lookup_word,
  output logic            hit,
  output logic [XLEN-1:0] hit_target,
  input  logic            upd_valid,
  input  logic            upd_taken,
  input  logic [XLEN-3:0] upd_word,
  input  logic [XLEN-1:0] upd_target
);
  localparam int IDX_W = btb_idx_w(ENTRIES);
  localparam int TAG_W = btb_tag_w(XLEN, ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } btb_entry_t;

  // Only valid bits need the asynchronous clear; tag/target storage stays reset-free.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_entry, up_entry;
  logic             up_hit;

  assign lk_idx = lookup_word[IDX_W-1:0];
  assign lk_tag = lookup_word[XLEN-3:IDX_W];
  assign up_idx = upd_word[IDX_W-1:0];
  assign up_tag = upd_word[XLEN-3:IDX_W];

  always_comb begin
    lk_entry   = '{valid: valid_q[lk_idx], tag: tag_q[lk_idx], target: target_q[lk_idx]};
    up_entry   = '{valid: valid_q[up_idx], tag: tag_q[up_idx], target: target_q[up_idx]};
    hit        = lk_entry.valid && (lk_entry.tag == lk_tag);
    up_hit     = up_entry.valid && (up_entry.tag == up_tag);
    hit_target = hit ? lk_entry.target : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid) begin
      if (upd_taken)   valid_q[up_idx] <= 1'b1;
      else if (up_hit) valid_q[up_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage program counter with BTB prediction, stall, trap and EX redirect
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0100,
  parameter int              BTB_ENTRIES = 16
) (
  input logic   clk,
  input logic   reset,
  pc_gen_if.slave bus
);
  logic [XLEN-1:0] pc_q, pc_next, redirect_target;
  logic [XLEN-1:0] btb_target;
  logic            btb_hit;
  next_sel_e       sel;

  pc_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .lookup_word (pc_q[XLEN-1:2]),
    .hit         (btb_hit),
    .hit_target  (btb_target),
    .upd_valid   (bus.ex_valid),
    .upd_taken   (bus.ex_taken),
    .upd_word    (bus.ex_pc[XLEN-1:2]),
    .upd_target  (redirect_target)
  );

  // Only JALR results are re-aligned; branch/JAL targets pass through untouched.
  always_comb begin
    if (bus.ex_jalr)       redirect_target = bus.ex_rs_imm & ~XLEN'(1);
    else if (bus.ex_taken) redirect_target = bus.ex_pc + bus.ex_imm;
    else                   redirect_target = bus.ex_pc + XLEN'(4);
  end

  always_comb begin
    if (bus.trap)                               sel = SEL_TRAP;
    else if (bus.ex_valid && bus.ex_mispredict) sel = SEL_REDIRECT;
    else if (bus.stall)                         sel = SEL_HOLD;
    else if (btb_hit)                           sel = SEL_PRED;
    else                                        sel = SEL_SEQ;
  end

  always_comb begin
    case (sel)
      SEL_TRAP:     pc_next = TRAP_VEC;
      SEL_REDIRECT: pc_next = redirect_target;
      SEL_HOLD:     pc_next = pc_q;
      SEL_PRED:     pc_next = btb_target;
      default:      pc_next = pc_q + XLEN'(4);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_next;
  end

  assign bus.pc_addr     = pc_q;
  assign bus.pc_save     = pc_q + XLEN'(4);
  assign bus.pred_taken  = btb_hit;
  assign bus.pred_target = btb_target;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen: directed table, corner sequences, random vs model
module tb_pc_gen;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          NENT      = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN        (32),
    .RESET_VEC   (RESET_VEC),
    .TRAP_VEC    (TRAP_VEC),
    .BTB_ENTRIES (NENT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the BTB is a table of remembered branch PCs and their targets;
  // a fetch hits when the slot chosen by its word address remembers that same word.
  logic [31:0] m_pc;
  logic [31:0] m_owner [NENT];
  logic [31:0] m_tgt   [NENT];
  bit          m_val   [NENT];

  function automatic int slot_of(logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int s;
    s = slot_of(pc);
    return m_val[s] && ((m_owner[s] >> 2) == (pc >> 2));
  endfunction

  task automatic model_reset();
    m_pc = RESET_VEC;
    for (int i = 0; i < NENT; i++) m_val[i] = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    bit h;
    h = m_hit(m_pc);
    chk("pc_addr", bus.pc_addr, m_pc);
    chk("pc_save", bus.pc_save, m_pc + 32'd4);
    chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, h});
    chk("pred_target", bus.pred_target, h ? m_tgt[slot_of(m_pc)] : 32'd0);
  endtask

  task automatic set_in(input bit s, input bit t, input bit v, input bit m, input bit j,
                        input bit k, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs);
    bus.stall = s; bus.trap = t; bus.ex_valid = v; bus.ex_mispredict = m;
    bus.ex_jalr = j; bus.ex_taken = k; bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_rs_imm = rs;
  endtask

  // Advance one clock, evolving the model from the inputs currently applied.
  task automatic tick();
    logic [31:0] rt, nxt;
    int          s;
    if (bus.ex_jalr)       rt = {bus.ex_rs_imm[31:1], 1'b0};
    else if (bus.ex_taken) rt = bus.ex_pc + bus.ex_imm;
    else                   rt = bus.ex_pc + 32'd4;
    if (bus.trap)                               nxt = TRAP_VEC;
    else if (bus.ex_valid && bus.ex_mispredict) nxt = rt;
    else if (bus.stall)                         nxt = m_pc;
    else if (m_hit(m_pc))                       nxt = m_tgt[slot_of(m_pc)];
    else                                        nxt = m_pc + 32'd4;
    s = slot_of(bus.ex_pc);
    if (bus.ex_valid) begin
      if (bus.ex_taken) begin
        m_val[s] = 1; m_owner[s] = bus.ex_pc; m_tgt[s] = rt;
      end else if (m_hit(bus.ex_pc)) begin
        m_val[s] = 0;
      end
    end
    @(posedge clk);
    #1;
    m_pc = nxt;
    check_model();
  endtask

  typedef struct {
    bit          s, t, v, m, j, k;
    logic [31:0] pc, imm, rs;
    logic [31:0] exp_pc;
    bit          exp_pred;
    logic [31:0] exp_tgt;
  } vec_t;

  function automatic vec_t mk(bit s, bit t, bit v, bit m, bit j, bit k,
                              logic [31:0] pc, logic [31:0] imm, logic [31:0] rs,
                              logic [31:0] epc, bit ep, logic [31:0] etgt);
    vec_t r;
    r.s = s; r.t = t; r.v = v; r.m = m; r.j = j; r.k = k;
    r.pc = pc; r.imm = imm; r.rs = rs;
    r.exp_pc = epc; r.exp_pred = ep; r.exp_tgt = etgt;
    return r;
  endfunction

  vec_t vecs [18];

  initial begin
    vecs[0]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h4,   0, 32'h0);
    vecs[1]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h8,   0, 32'h0);
    vecs[2]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'hC,   0, 32'h0);
    vecs[3]  = mk(0,0,1,1,0,1, 32'h8,   32'd12, 32'h0,  32'h14,  0, 32'h0);
    vecs[4]  = mk(0,0,1,1,1,1, 32'h30,  32'h0,  32'h65, 32'h64,  0, 32'h0);
    vecs[5]  = mk(0,0,1,1,0,1, 32'h4,   32'h4,  32'h0,  32'h8,   1, 32'h14);
    vecs[6]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h14,  0, 32'h0);
    vecs[7]  = mk(0,0,1,1,0,0, 32'h8,   32'h0,  32'h0,  32'hC,   0, 32'h0);
    vecs[8]  = mk(0,0,1,1,0,1, 32'h0,   32'h8,  32'h0,  32'h8,   0, 32'h0);
    vecs[9]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'hC,   0, 32'h0);
    vecs[10] = mk(0,0,1,1,1,1, 32'h3C,  32'h0,  32'h20, 32'h20,  0, 32'h0);
    vecs[11] = mk(1,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h20,  0, 32'h0);
    vecs[12] = mk(1,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h20,  0, 32'h0);
    vecs[13] = mk(1,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h20,  0, 32'h0);
    vecs[14] = mk(1,0,1,1,0,1, 32'h38,  32'h8,  32'h0,  32'h40,  0, 32'h0);
    vecs[15] = mk(0,1,1,1,0,1, 32'h10,  32'h30, 32'h0,  32'h100, 0, 32'h0);
    vecs[16] = mk(0,0,1,1,1,1, 32'h200, 32'h0,  32'h10, 32'h10,  1, 32'h40);
    vecs[17] = mk(0,0,0,0,0,0, 32'h0,   32'h0,  32'h0,  32'h40,  0, 32'h0);

    reset = 1'b1;
    set_in(0,0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    model_reset();
    #2;
    chk("reset pc_addr", bus.pc_addr, 32'h0);
    chk("reset pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    chk("reset pred_target", bus.pred_target, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_model();

    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].s, vecs[i].t, vecs[i].v, vecs[i].m, vecs[i].j, vecs[i].k,
             vecs[i].pc, vecs[i].imm, vecs[i].rs);
      tick();
      chk($sformatf("vec%0d pc_addr", i), bus.pc_addr, vecs[i].exp_pc);
      chk($sformatf("vec%0d pred_taken", i), {31'd0, bus.pred_taken}, {31'd0, vecs[i].exp_pred});
      chk($sformatf("vec%0d pred_target", i), bus.pred_target, vecs[i].exp_tgt);
    end

    // Wrap at the top of the address space.
    set_in(0,0,1,1,1,1, 32'h300, 32'h0, 32'hFFFF_FFFD);
    tick();
    chk("wrap pc_addr", bus.pc_addr, 32'hFFFF_FFFC);
    chk("wrap pc_save", bus.pc_save, 32'h0);
    set_in(0,0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("wrap next", bus.pc_addr, 32'h0);

    // Train 0x8 again, then reset mid-cycle and confirm the BTB forgot it.
    set_in(0,0,1,1,0,1, 32'h8, 32'h10, 32'h0);
    tick();
    chk("retrain pc", bus.pc_addr, 32'h18);
    set_in(0,0,1,1,0,1, 32'h4, 32'h4, 32'h0);
    tick();
    chk("retrain pred", {31'd0, bus.pred_taken}, 32'd1);
    chk("retrain target", bus.pred_target, 32'h18);
    set_in(0,0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    #3;
    reset = 1'b1;
    #1;
    chk("async pc_addr", bus.pc_addr, 32'h0);
    chk("async pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    chk("async pred_target", bus.pred_target, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check_model();
    reset = 1'b0;
    tick();
    chk("post reset pc", bus.pc_addr, 32'h4);
    tick();
    chk("post reset pc8", bus.pc_addr, 32'h8);
    chk("post reset pred", {31'd0, bus.pred_taken}, 32'd0);

    for (int n = 0; n < 1500; n++) begin
      bit          j;
      logic [31:0] epc;
      j   = ($urandom_range(0, 3) == 0);
      epc = ($urandom_range(0, 1) ? 32'h0 : 32'h400) + 32'(4 * $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) epc = m_pc;
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, j,
             j ? 1'b1 : 1'($urandom_range(0, 1)), epc,
             32'(4 * $urandom_range(0, 31)) - 32'd64, 32'($urandom_range(0, 255)));
      tick();
    end

    set_in(0,0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
